// File: rtl/design1_wrapper.sv
// AXI4-Lite slave: DIN/MASK/DEST register block whose DIN writes land masked in a word BRAM,
// plus a direct byte-addressable window onto the same BRAM.
module design1_wrapper #(
   parameter logic [31:0] MASK_BASE = 32'h7600_0000,
   parameter logic [31:0] BRAM_BASE = 32'hC000_0000,
   parameter int          DEPTH     = 1024,
   parameter logic [31:0] MASK_RST  = 32'h0000_FFFF
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic [31:0] s_awaddr,
   input  logic        s_awvalid,
   output logic        s_awready,
   input  logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   input  logic        s_wvalid,
   output logic        s_wready,
   output logic [1:0]  s_bresp,
   output logic        s_bvalid,
   input  logic        s_bready,
   input  logic [31:0] s_araddr,
   input  logic        s_arvalid,
   output logic        s_arready,
   output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        s_rvalid,
   input  logic        s_rready
);
   localparam int          IDX_W     = $clog2(DEPTH);
   localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);
   localparam logic [1:0]  OKAY      = 2'b00;
   localparam logic [1:0]  DECERR    = 2'b11;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} wstate_t;
   typedef enum logic [1:0] {HIT_NONE, HIT_REG, HIT_MEM} hit_t;

   wstate_t     state;
   logic [31:0] aw_addr, w_data;
   logic [3:0]  w_strb;
   logic        aw_held, w_held;
   logic [31:0] din_reg, mask_reg, dest_reg;
   logic [31:0] mem [DEPTH];

   function automatic hit_t decode(input logic [31:0] a);
      hit_t        kind;
      logic [31:0] off;
      off  = a - BRAM_BASE;
      kind = HIT_NONE;
      if (a[31:12] == MASK_BASE[31:12] && a[11:2] < 10'd3)
         kind = HIT_REG;
      else if (off < MEM_BYTES)
         kind = HIT_MEM;
      return kind;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_word, input logic [31:0] new_word,
                                         input logic [3:0] strb);
      logic [31:0] res;
      res = old_word;
      for (int b = 0; b < 4; b++)
         if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
      return res;
   endfunction

   logic        aw_hs, w_hs, ar_hs;
   hit_t        wr_kind, rd_kind;
   logic [31:0] wr_off, rd_off;
   logic        mem_we;
   logic [IDX_W-1:0] mem_idx, rd_idx;
   logic [31:0] mem_new, rd_word, rd_data;
   logic [1:0]  rd_resp;

   assign aw_hs   = s_awvalid && s_awready;
   assign w_hs    = s_wvalid && s_wready;
   assign ar_hs   = s_arvalid && s_arready;
   assign wr_kind = decode(aw_addr);
   assign rd_kind = decode(s_araddr);
   assign wr_off  = aw_addr - BRAM_BASE;
   assign rd_off  = s_araddr - BRAM_BASE;
   assign rd_idx  = rd_off[IDX_W+1:2];

   // The pending BRAM update is visible to a read accepted in the same cycle (write-first).
   always_comb begin
      mem_we  = 1'b0;
      mem_idx = '0;
      mem_new = '0;
      if (state == EXEC) begin
         if (wr_kind == HIT_REG && aw_addr[3:2] == 2'd0) begin
            mem_we  = 1'b1;
            mem_idx = dest_reg[IDX_W-1:0];
            mem_new = w_data & mask_reg;
         end else if (wr_kind == HIT_MEM) begin
            mem_we  = 1'b1;
            mem_idx = wr_off[IDX_W+1:2];
            mem_new = merge(mem[wr_off[IDX_W+1:2]], w_data, w_strb);
         end
      end
   end

   always_comb begin
      rd_word = (mem_we && mem_idx == rd_idx) ? mem_new : mem[rd_idx];
      rd_data = '0;
      rd_resp = OKAY;
      case (rd_kind)
         HIT_REG: begin
            case (s_araddr[3:2])
               2'd0:    rd_data = din_reg;
               2'd1:    rd_data = mask_reg;
               default: rd_data = dest_reg;
            endcase
         end
         HIT_MEM: rd_data = rd_word >> {rd_off[1:0], 3'b000};
         default: rd_resp = DECERR;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (mem_we) mem[mem_idx] <= mem_new;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state     <= IDLE;
         aw_addr   <= '0;
         w_data    <= '0;
         w_strb    <= '0;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         din_reg   <= '0;
         mask_reg  <= MASK_RST;
         dest_reg  <= '0;
         s_awready <= 1'b0;
         s_wready  <= 1'b0;
         s_bvalid  <= 1'b0;
         s_bresp   <= OKAY;
         s_arready <= 1'b0;
         s_rvalid  <= 1'b0;
         s_rdata   <= '0;
         s_rresp   <= OKAY;
      end else begin
         case (state)
            IDLE: begin
               if (aw_hs) begin
                  aw_addr <= s_awaddr;
                  aw_held <= 1'b1;
               end
               if (w_hs) begin
                  w_data <= s_wdata;
                  w_strb <= s_wstrb;
                  w_held <= 1'b1;
               end
               s_awready <= !(aw_held || aw_hs);
               s_wready  <= !(w_held || w_hs);
               if ((aw_held || aw_hs) && (w_held || w_hs))
                  state <= EXEC;
            end
            EXEC: begin
               if (wr_kind == HIT_REG) begin
                  case (aw_addr[3:2])
                     2'd0:    din_reg  <= merge(din_reg, w_data, w_strb);
                     2'd1:    mask_reg <= merge(mask_reg, w_data, w_strb);
                     default: dest_reg <= merge(dest_reg, w_data, w_strb);
                  endcase
               end
               s_bresp  <= (wr_kind == HIT_NONE) ? DECERR : OKAY;
               s_bvalid <= 1'b1;
               state    <= RESP;
            end
            default: begin
               if (s_bready) begin
                  s_bvalid  <= 1'b0;
                  aw_held   <= 1'b0;
                  w_held    <= 1'b0;
                  s_awready <= 1'b1;
                  s_wready  <= 1'b1;
                  state     <= IDLE;
               end
            end
         endcase

         if (ar_hs) begin
            s_arready <= 1'b0;
            s_rvalid  <= 1'b1;
            s_rdata   <= rd_data;
            s_rresp   <= rd_resp;
         end else if (s_rvalid) begin
            if (s_rready) begin
               s_rvalid  <= 1'b0;
               s_arready <= 1'b1;
            end
         end else begin
            s_arready <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_design1_wrapper.sv
// Randomized AXI4-Lite bench for design1_wrapper, checked against a word-level model of the
// register block and BRAM.
module tb_design1_wrapper;
   localparam logic [31:0] MASK_BASE = 32'h7600_0000;
   localparam logic [31:0] BRAM_BASE = 32'hC000_0000;
   localparam int          DEPTH     = 1024;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [31:0] s_awaddr = '0;
   logic        s_awvalid = 1'b0;
   logic        s_awready;
   logic [31:0] s_wdata = '0;
   logic [3:0]  s_wstrb = '0;
   logic        s_wvalid = 1'b0;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready = 1'b0;
   logic [31:0] s_araddr = '0;
   logic        s_arvalid = 1'b0;
   logic        s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid;
   logic        s_rready = 1'b0;

   design1_wrapper dut (
      .aclk(aclk), .areset(areset),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
   );

   always #5 aclk = ~aclk;

   int passCount = 0;
   int checkCount = 0;

   logic [31:0] refDin, refMask, refDest;
   logic [31:0] refMem [DEPTH];
   bit          refValid [DEPTH];

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got === exp) passCount++;
      else $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [31:0] byteMerge(input logic [31:0] oldW, input logic [31:0] newW,
                                             input logic [3:0] strb);
      logic [31:0] r;
      r = oldW;
      for (int b = 0; b < 4; b++)
         if (strb[b]) r[8*b +: 8] = newW[8*b +: 8];
      return r;
   endfunction

   function automatic bit isReg(input logic [31:0] a);
      return a >= MASK_BASE && a < MASK_BASE + 32'd12;
   endfunction

   function automatic bit isMem(input logic [31:0] a);
      return a >= BRAM_BASE && a < BRAM_BASE + 32'(DEPTH * 4);
   endfunction

   task automatic modelReset();
      refDin  = '0;
      refMask = 32'h0000_FFFF;
      refDest = '0;
   endtask

   task automatic modelWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb,
                             output logic [1:0] expResp);
      int w;
      expResp = 2'b00;
      if (isReg(a)) begin
         case ((a - MASK_BASE) / 4)
            0: begin
               refDin = byteMerge(refDin, d, strb);
               w = int'(refDest % DEPTH);
               refMem[w]   = d & refMask;
               refValid[w] = 1'b1;
            end
            1: refMask = byteMerge(refMask, d, strb);
            default: refDest = byteMerge(refDest, d, strb);
         endcase
      end else if (isMem(a)) begin
         w = int'((a - BRAM_BASE) / 4);
         refMem[w] = byteMerge(refMem[w], d, strb);
         if (strb == 4'hF) refValid[w] = 1'b1;
      end else begin
         expResp = 2'b11;
      end
   endtask

   task automatic modelRead(input logic [31:0] a, output logic [31:0] expData,
                            output logic [1:0] expResp);
      expData = '0;
      expResp = 2'b00;
      if (isReg(a)) begin
         case ((a - MASK_BASE) / 4)
            0: expData = refDin;
            1: expData = refMask;
            default: expData = refDest;
         endcase
      end else if (isMem(a)) begin
         expData = refMem[(a - BRAM_BASE) / 4] >> (8 * (a % 4));
      end else begin
         expResp = 2'b11;
      end
   endtask

   // Caller must be sitting on a negedge; returns on a negedge.
   task automatic axiWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb,
                           input int awDly, input int wDly, input int bDly,
                           output logic [1:0] resp);
      bit awLate = 1'b0;
      bit wLate = 1'b0;
      fork
         begin
            repeat (awDly) @(negedge aclk);
            s_awaddr = a;
            s_awvalid = 1'b1;
            for (int i = 0; i < 64 && s_awready !== 1'b1; i++) @(negedge aclk);
            if (s_awready !== 1'b1) awLate = 1'b1;
            @(negedge aclk);
            s_awvalid = 1'b0;
         end
         begin
            repeat (wDly) @(negedge aclk);
            s_wdata = d;
            s_wstrb = strb;
            s_wvalid = 1'b1;
            for (int i = 0; i < 64 && s_wready !== 1'b1; i++) @(negedge aclk);
            if (s_wready !== 1'b1) wLate = 1'b1;
            @(negedge aclk);
            s_wvalid = 1'b0;
         end
      join
      if (awLate) checkOutput("aw_timeout", 32'(awLate), 32'd0);
      if (wLate) checkOutput("w_timeout", 32'(wLate), 32'd0);
      for (int i = 0; i < 64 && s_bvalid !== 1'b1; i++) @(negedge aclk);
      if (s_bvalid !== 1'b1) begin
         checkOutput("b_timeout", 32'(s_bvalid), 32'd1);
         resp = 2'bxx;
      end else begin
         for (int i = 0; i < bDly; i++) begin
            @(negedge aclk);
            checkOutput("bvalid_hold", 32'(s_bvalid), 32'd1);
         end
         resp = s_bresp;
         s_bready = 1'b1;
         @(negedge aclk);
         s_bready = 1'b0;
         checkOutput("bvalid_single", 32'(s_bvalid), 32'd0);
      end
   endtask

   task automatic axiRead(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      s_araddr = a;
      s_arvalid = 1'b1;
      for (int i = 0; i < 64 && s_arready !== 1'b1; i++) @(negedge aclk);
      if (s_arready !== 1'b1) checkOutput("ar_timeout", 32'(s_arready), 32'd1);
      @(negedge aclk);
      s_arvalid = 1'b0;
      for (int i = 0; i < 64 && s_rvalid !== 1'b1; i++) @(negedge aclk);
      if (s_rvalid !== 1'b1) begin
         checkOutput("r_timeout", 32'(s_rvalid), 32'd1);
         d = 'x;
         resp = 2'bxx;
      end else begin
         d = s_rdata;
         resp = s_rresp;
         s_rready = 1'b1;
         @(negedge aclk);
         s_rready = 1'b0;
      end
   endtask

   task automatic writeAndCheck(input string tag, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] strb, input int awDly, input int wDly,
                                input int bDly);
      logic [1:0] resp, expResp;
      axiWrite(a, d, strb, awDly, wDly, bDly, resp);
      modelWrite(a, d, strb, expResp);
      checkOutput(tag, 32'(resp), 32'(expResp));
   endtask

   task automatic readAndCheck(input string tag, input logic [31:0] a);
      logic [31:0] d, expData;
      logic [1:0]  resp, expResp;
      axiRead(a, d, resp);
      modelRead(a, expData, expResp);
      checkOutput(tag, d, expData);
      checkOutput({tag, "_resp"}, 32'(resp), 32'(expResp));
   endtask

   task automatic applyStimulus();
      int op, w;
      logic [31:0] d;
      logic [3:0]  strb;
      op = $urandom_range(0, 7);
      d  = $urandom;
      case (op)
         0, 1: writeAndCheck("rnd_din", MASK_BASE, d, 4'hF, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
         2: begin
            strb = 4'($urandom_range(1, 15));
            writeAndCheck("rnd_mask", MASK_BASE + 32'd4, d, strb, $urandom_range(0, 3), $urandom_range(0, 3), 0);
         end
         3: writeAndCheck("rnd_dest", MASK_BASE + 32'd8, 32'($urandom_range(0, DEPTH - 1)), 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), 0);
         4: begin
            w = $urandom_range(0, DEPTH - 1);
            strb = refValid[w] ? 4'($urandom_range(1, 15)) : 4'hF;
            writeAndCheck("rnd_bram_wr", BRAM_BASE + 32'(w * 4), d, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
         end
         5: readAndCheck("rnd_reg_rd", MASK_BASE + 32'($urandom_range(0, 2) * 4));
         6: begin
            w = int'(refDest % DEPTH);
            if (refValid[w])
               readAndCheck("rnd_bram_rd", BRAM_BASE + 32'(w * 4) + 32'($urandom_range(0, 3)));
            else
               readAndCheck("rnd_reg_rd", MASK_BASE);
         end
         default: begin
            if ($urandom_range(0, 1) == 0)
               writeAndCheck("rnd_unmapped_wr", 32'h1000_0000 + 32'($urandom_range(0, 255) * 4), d, 4'hF, 0, 0, 0);
            else
               readAndCheck("rnd_unmapped_rd", BRAM_BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255)));
         end
      endcase
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] d, v;
      logic [1:0]  resp;
      int          k;
      for (int i = 0; i < DEPTH; i++) refValid[i] = 1'b0;
      modelReset();

      repeat (3) @(negedge aclk);
      checkOutput("rst_awready", 32'(s_awready), 32'd0);
      checkOutput("rst_wready", 32'(s_wready), 32'd0);
      checkOutput("rst_arready", 32'(s_arready), 32'd0);
      checkOutput("rst_bvalid", 32'(s_bvalid), 32'd0);
      checkOutput("rst_rvalid", 32'(s_rvalid), 32'd0);
      checkOutput("rst_rdata", s_rdata, 32'd0);
      areset = 1'b0;
      @(negedge aclk);
      checkOutput("ready_after_rst", {29'd0, s_awready, s_wready, s_arready}, 32'd7);

      readAndCheck("rst_mask", MASK_BASE + 32'd4);
      readAndCheck("rst_din", MASK_BASE);

      // Default mask keeps only the low half-word.
      writeAndCheck("deadbeef_wr", MASK_BASE, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
      axiRead(BRAM_BASE, d, resp);
      checkOutput("beef_word", d, 32'h0000_BEEF);
      axiRead(BRAM_BASE + 32'd1, d, resp);
      checkOutput("beef_byte1", {24'd0, d[7:0]}, 32'hBE);
      readAndCheck("beef_byte2", BRAM_BASE + 32'd2);
      readAndCheck("beef_byte3", BRAM_BASE + 32'd3);

      writeAndCheck("mask_wr", MASK_BASE + 32'd4, 32'hFF00_FF00, 4'hF, 0, 0, 0);
      writeAndCheck("din_wr", MASK_BASE, 32'h1234_5678, 4'hF, 0, 0, 0);
      axiRead(BRAM_BASE, d, resp);
      checkOutput("masked_word", d, 32'h1200_5600);
      axiRead(MASK_BASE + 32'd4, d, resp);
      checkOutput("mask_rd", d, 32'hFF00_FF00);

      writeAndCheck("mask_restore", MASK_BASE + 32'd4, 32'h0000_FFFF, 4'hF, 0, 0, 0);
      writeAndCheck("dest_wr", MASK_BASE + 32'd8, 32'd5, 4'hF, 0, 0, 0);
      writeAndCheck("din_ones", MASK_BASE, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
      axiRead(BRAM_BASE + 32'h14, d, resp);
      checkOutput("dest5_word", d, 32'h0000_FFFF);
      axiRead(BRAM_BASE, d, resp);
      checkOutput("word0_kept", d, 32'h1200_5600);

      axiWrite(32'h1000_0000, 32'h5555_5555, 4'hF, 0, 0, 0, resp);
      checkOutput("unmapped_bresp", 32'(resp), 32'd3);
      axiRead(32'h1000_0000, d, resp);
      checkOutput("unmapped_rdata", d, 32'd0);
      checkOutput("unmapped_rresp", 32'(resp), 32'd3);
      readAndCheck("bram_past_end", BRAM_BASE + 32'(DEPTH * 4));

      writeAndCheck("aw_before_w", BRAM_BASE + 32'h20, 32'hCAFE_F00D, 4'hF, 0, 3, 4);
      writeAndCheck("w_before_aw", BRAM_BASE + 32'h20, 32'hAB00_0000, 4'h8, 2, 0, 1);
      readAndCheck("strb_merge", BRAM_BASE + 32'h20);
      readAndCheck("strb_merge_b3", BRAM_BASE + 32'h23);

      // Abort a MASK write while it sits in EXEC.
      s_awaddr = MASK_BASE + 32'd4;
      s_wdata = 32'h1234_5678;
      s_wstrb = 4'hF;
      s_awvalid = 1'b1;
      s_wvalid = 1'b1;
      @(negedge aclk);
      s_awvalid = 1'b0;
      s_wvalid = 1'b0;
      areset = 1'b1;
      #1;
      checkOutput("abort_valids", {30'd0, s_bvalid, s_rvalid}, 32'd0);
      checkOutput("abort_awready", 32'(s_awready), 32'd0);
      modelReset();
      @(negedge aclk);
      areset = 1'b0;
      @(negedge aclk);
      readAndCheck("abort_mask", MASK_BASE + 32'd4);
      writeAndCheck("post_abort_wr", MASK_BASE, 32'h0BAD_F00D, 4'hF, 1, 0, 0);
      readAndCheck("post_abort_rd", BRAM_BASE);

      // Sweep of DIN values across every BRAM word.
      for (int i = 0; i < DEPTH; i++) begin
         case (i)
            0: v = 32'hFFFF_FFFF;
            1: v = 32'hFFFF_FFFE;
            2: v = 32'h8000_0000;
            3: v = 32'h0000_0000;
            default: v = $urandom;
         endcase
         writeAndCheck("sweep_dest", MASK_BASE + 32'd8, 32'(i), 4'hF, 0, 0, 0);
         writeAndCheck("sweep_din", MASK_BASE, v, 4'hF, 0, 0, 0);
         k = $urandom_range(0, 3);
         readAndCheck("sweep_byte", BRAM_BASE + 32'(i * 4) + 32'(k));
      end

      for (int i = 0; i < 400; i++) applyStimulus();

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
